// File: rtl/spinet_pkg.sv
// Shared definitions for the SPInet ring master: FSM encoding and packet field positions.
package spinet_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StSetup = 3'd1;
    localparam state_t StHigh  = 3'd2;
    localparam state_t StLow   = 3'd3;
    localparam state_t StHold  = 3'd4;
    localparam state_t StGap   = 3'd5;

    // FULL marks a packet that carries payload; ACK sits just below it.
    function automatic int unsigned full_pos(input int unsigned width);
        return width - 1;
    endfunction

    function automatic int unsigned ack_pos(input int unsigned width);
        return width - 2;
    endfunction

endpackage

// File: rtl/spinet_master_if.sv
// Client handshake, ring-node status and SPI pins of the SPInet master.
interface spinet_master_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             node_txready;
    logic             node_rxready;
    logic             SCLK;
    logic             SS;
    logic             MOSI;
    logic             MISO;

    modport master (
        input  tx_data, tx_valid, rx_ready, node_txready, node_rxready, MISO,
        output tx_ready, rx_data, rx_valid, SCLK, SS, MOSI
    );

    modport slave (
        output tx_data, tx_valid, rx_ready, node_txready, node_rxready, MISO,
        input  tx_ready, rx_data, rx_valid, SCLK, SS, MOSI
    );

endinterface

// File: rtl/spinet_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module spinet_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spinet_master.sv
// SPI master bridging a host client to a SPInet ring node: one full-duplex word per transfer,
// received words are kept only when their FULL bit is set.
module spinet_master
    import spinet_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned GAP    = 8
) (
    input logic             clk,
    input logic             rst_n,
    spinet_master_if.master bus
);

    localparam int unsigned CntMax  = (CLKDIV > GAP) ? CLKDIV : GAP;
    localparam int unsigned CntW    = $clog2(CntMax);
    localparam int unsigned BitW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned FullPos = full_pos(WIDTH);

    localparam logic [CntW-1:0] DivLast = CntW'(CLKDIV - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GAP - 1);

    logic txr_s;
    logic rxr_s;

    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sclk_q, sclk_d;
    logic             ss_q, ss_d;
    logic             mosi_q, mosi_d;
    logic             tx_ready_q, tx_ready_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic start;
    logic last;

    spinet_sync2 u_txr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.node_txready),
        .q_o   (txr_s)
    );

    spinet_sync2 u_rxr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.node_rxready),
        .q_o   (rxr_s)
    );

    // tx_ready already folds in txr_s and rx_valid, so it gates rx-only starts as well.
    assign start = tx_ready_q && (bus.tx_valid || rxr_s);
    assign last  = (state_q == StGap) ? (cnt_q == GapLast) : (cnt_q == DivLast);

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        cnt_d      = (state_q == StIdle || last) ? '0 : cnt_q + CntW'(1);

        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    bit_d   = BitW'(WIDTH - 1);
                    shreg_d = bus.tx_valid ? bus.tx_data : '0;
                end
            end
            StSetup: begin
                if (last) state_d = StHigh;
            end
            StHigh: begin
                if (last) begin
                    state_d = StLow;
                    shreg_d = {shreg_q[WIDTH-2:0], bus.MISO};
                end
            end
            StLow: begin
                if (last) begin
                    if (bit_q == '0) begin
                        state_d = StHold;
                    end else begin
                        state_d = StHigh;
                        bit_d   = bit_q - BitW'(1);
                    end
                end
            end
            StHold: begin
                if (last) begin
                    state_d = StGap;
                    if (shreg_q[FullPos]) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            StGap: begin
                if (last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Pins are registered from the next state so they change glitch-free with the FSM.
        sclk_d     = (state_d == StHigh);
        ss_d       = !(state_d inside {StSetup, StHigh, StLow, StHold});
        mosi_d     = (state_d inside {StSetup, StHigh} ||
                      (state_d == StLow && bit_d != '0)) ? shreg_d[FullPos] : 1'b0;
        tx_ready_d = (state_d == StIdle) && txr_s && !rx_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            sclk_q     <= 1'b0;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            sclk_q     <= sclk_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus.SCLK     = sclk_q;
    assign bus.SS       = ss_q;
    assign bus.MOSI     = mosi_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spinet_master.sv
// Self-checking bench for spinet_master: directed cases plus random full-duplex words.
module tb_spinet_master;

    localparam int unsigned W     = 16;
    localparam int unsigned CD    = 4;
    localparam int unsigned GP    = 8;
    localparam int unsigned SsLow = CD * (2 * W + 2);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spinet_master_if #(.WIDTH(W)) bus ();

    spinet_master #(
        .WIDTH  (W),
        .CLKDIV (CD),
        .GAP    (GP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model: shifts slave_word out on MISO and captures MOSI on every SCLK rise.
    logic [W-1:0] slave_word = '0;
    logic [W-1:0] mosi_cap   = '0;
    int           pulses     = 0;
    int           sidx       = 0;
    logic         ss_prev    = 1'b1;
    logic         sclk_prev  = 1'b0;

    always @(negedge clk) begin
        ss_prev   <= bus.SS;
        sclk_prev <= bus.SCLK;
        if (!rst_n) begin
            bus.MISO <= 1'b0;
        end else if (ss_prev && !bus.SS) begin
            sidx     <= W - 1;
            bus.MISO <= slave_word[W-1];
            pulses   <= 0;
            mosi_cap <= '0;
        end else if (!bus.SS) begin
            if (!sclk_prev && bus.SCLK) begin
                pulses   <= pulses + 1;
                mosi_cap <= {mosi_cap[W-2:0], bus.MOSI};
            end
            if (sclk_prev && !bus.SCLK && sidx > 0) begin
                sidx     <= sidx - 1;
                bus.MISO <= slave_word[sidx-1];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // One word on the wire, checked against what the client and the node should see.
    task automatic xfer(input string tag, input bit use_tx, input logic [W-1:0] txw,
                        input logic [W-1:0] slw, input bit use_rxr, input bit consume);
        int n;
        bit got;
        logic [W-1:0] want_mosi;
        want_mosi        = use_tx ? txw : '0;
        slave_word       = slw;
        bus.tx_data      = txw;
        bus.tx_valid     = use_tx;
        bus.node_rxready = use_rxr;
        got = 0;
        n   = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.SS === 1'b0) got = 1;
        end
        bus.tx_valid     = 1'b0;
        bus.node_rxready = 1'b0;
        chk({tag, " start"}, 32'(got), 32'd1);
        if (!got) return;
        n = 1;
        while (n < 400) begin
            @(negedge clk);
            if (bus.SS !== 1'b0) break;
            n++;
        end
        chk({tag, " ss_low_cycles"}, n, SsLow);
        chk({tag, " sclk_pulses"}, pulses, W);
        chk({tag, " mosi_word"}, 32'(mosi_cap), 32'(want_mosi));
        chk({tag, " gap_mosi"}, 32'(bus.MOSI), 32'd0);
        chk({tag, " gap_sclk"}, 32'(bus.SCLK), 32'd0);
        if (slw[W-1]) begin
            chk({tag, " rx_valid"}, 32'(bus.rx_valid), 32'd1);
            chk({tag, " rx_data"}, 32'(bus.rx_data), 32'(slw));
            if (consume) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                chk({tag, " rx_hold"}, 32'(bus.rx_valid), 32'd1);
                bus.rx_ready = 1'b1;
                @(negedge clk);
                bus.rx_ready = 1'b0;
                chk({tag, " rx_clear"}, 32'(bus.rx_valid), 32'd0);
            end
        end else begin
            chk({tag, " rx_dropped"}, 32'(bus.rx_valid), 32'd0);
            n = 0;
            while (bus.tx_ready !== 1'b1 && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk({tag, " gap_cycles"}, n, GP);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ss_seen;
        int mode;
        logic [W-1:0] txw;
        logic [W-1:0] slw;

        bus.tx_data      = '0;
        bus.tx_valid     = 1'b0;
        bus.rx_ready     = 1'b0;
        bus.node_txready = 1'b1;
        bus.node_rxready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset sclk", 32'(bus.SCLK), 32'd0);
        chk("reset ss", 32'(bus.SS), 32'd1);
        chk("reset mosi", 32'(bus.MOSI), 32'd0);
        chk("reset tx_ready", 32'(bus.tx_ready), 32'd0);
        chk("reset rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset rx_data", 32'(bus.rx_data), 32'd0);
        rst_n = 1'b1;

        xfer("tx_only", 1'b1, 16'h8A55, 16'h0000, 1'b0, 1'b1);
        xfer("rx_only", 1'b0, 16'h0000, 16'hC3F0, 1'b1, 1'b1);
        xfer("not_full", 1'b1, 16'h1234, 16'h0123, 1'b0, 1'b1);
        xfer("duplex", 1'b1, 16'h3C5A, 16'hB00B, 1'b1, 1'b1);

        // Node not ready: nothing may start, then tx_ready follows through the synchronizer.
        @(negedge clk);
        bus.node_txready = 1'b0;
        repeat (5) @(negedge clk);
        bus.tx_data  = 16'h4E21;
        bus.tx_valid = 1'b1;
        ss_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.SS !== 1'b1) ss_seen = 1;
        end
        chk("blocked tx_ready", 32'(bus.tx_ready), 32'd0);
        chk("blocked ss", 32'(ss_seen), 32'd0);
        bus.node_txready = 1'b1;
        @(negedge clk);
        chk("txr lag1", 32'(bus.tx_ready), 32'd0);
        @(negedge clk);
        chk("txr lag2", 32'(bus.tx_ready), 32'd0);
        @(negedge clk);
        chk("txr lag3", 32'(bus.tx_ready), 32'd1);
        xfer("after_block", 1'b1, 16'h4E21, 16'h0000, 1'b0, 1'b1);

        // Unconsumed packet holds off further node reads until the client takes it.
        xfer("hold_fill", 1'b0, 16'h0000, 16'h9999, 1'b1, 1'b0);
        bus.node_rxready = 1'b1;
        ss_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.SS !== 1'b1) ss_seen = 1;
        end
        chk("held ss", 32'(ss_seen), 32'd0);
        chk("held rx_valid", 32'(bus.rx_valid), 32'd1);
        chk("held tx_ready", 32'(bus.tx_ready), 32'd0);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        chk("held release", 32'(bus.rx_valid), 32'd0);
        xfer("hold_next", 1'b0, 16'h0000, 16'hA1B2, 1'b1, 1'b1);
        ss_seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.SS !== 1'b1) ss_seen = 1;
        end
        chk("single xfer", 32'(ss_seen), 32'd0);

        // Reset in the middle of bit 7 aborts the word.
        slave_word   = 16'hF00D;
        bus.tx_data  = 16'h7E81;
        bus.tx_valid = 1'b1;
        ss_seen = 0;
        for (int i = 0; i < 100 && !ss_seen; i++) begin
            @(negedge clk);
            if (bus.SS === 1'b0) ss_seen = 1;
        end
        bus.tx_valid = 1'b0;
        chk("abort start", 32'(ss_seen), 32'd1);
        repeat (CD + 2 * CD * 8 + 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort ss", 32'(bus.SS), 32'd1);
        chk("abort sclk", 32'(bus.SCLK), 32'd0);
        chk("abort rx_valid", 32'(bus.rx_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort ss_hold", 32'(bus.SS), 32'd1);
        chk("abort mosi", 32'(bus.MOSI), 32'd0);
        rst_n = 1'b1;
        xfer("post_reset", 1'b1, 16'h5AA5, 16'hE7C1, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            mode = $urandom_range(0, 2);
            txw  = W'($urandom);
            slw  = W'($urandom);
            xfer($sformatf("rand%0d", i), mode != 1, txw, slw, mode != 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
